// File: rtl/nexi_uart_pkg.sv
// Shared definitions for the UART receive path: byte width and RX controller state encoding.
package nexi_uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_CAPTURE = 2'd1,
    RX_ACK     = 2'd2,
    RX_ERR     = 2'd3
  } rx_state_e;

endpackage

// File: rtl/nexi_sync_fifo.sv
// Single-clock FIFO with exact occupancy; push and pop in the same cycle are both honoured,
// including at full. Depth must be a power of two (>= 2).
module nexi_sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       level_q, level_d;
  logic              do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == LVL_FULL);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A pop at full frees the slot the concurrent push needs.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/nexi_uart_rx_ctrl.sv
// UART RX controller: four-phase data_ready/read_ack handshake with the RX core, drains bytes into
// a FIFO exposed as a valid/ready stream. Optional byte/drop counters under NEXI_UART_RX_CTRL_STATS_EN.
module nexi_uart_rx_ctrl
  import nexi_uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int IRQ_THRESH  = 1,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic [UART_DATA_W-1:0]       rx_data,
  input  logic                         rx_data_ready,
  output logic                         rx_read_ack,
  output logic [UART_DATA_W-1:0]       out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         overrun,
  output logic                         ack_err,
  input  logic                         clr_status,
  output logic                         irq
`ifdef NEXI_UART_RX_CTRL_STATS_EN
  ,
  output logic [15:0]                  stat_rx_cnt,
  output logic [15:0]                  stat_drop_cnt
`endif
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);
  localparam logic [LW-1:0] IRQ_LVL  = LW'(IRQ_THRESH);

  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dr_meta_q, dr_s_q;
  logic          ack_q;
  logic          overrun_q, overrun_d;
  logic          ack_err_q, ack_err_d;
  logic          capture, err_set, pop, drop, fifo_full, fifo_empty;

  always_ff @(posedge clk) begin
    if (rst) begin
      dr_meta_q <= 1'b0;
      dr_s_q    <= 1'b0;
    end else begin
      dr_meta_q <= rx_data_ready;
      dr_s_q    <= dr_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    err_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (enable & dr_s_q) state_d = RX_CAPTURE;
      end
      RX_CAPTURE: begin
        capture = 1'b1;
        cnt_d   = '0;
        state_d = RX_ACK;
      end
      RX_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (!dr_s_q) begin
          state_d = RX_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = RX_ERR;
          err_set = 1'b1;
        end
      end
      RX_ERR: begin
        if (!dr_s_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= (state_d == RX_ACK);
    end
  end

  assign rx_read_ack = ack_q;

  assign pop  = out_ready & ~fifo_empty;
  assign drop = capture & fifo_full & ~pop;

  // A set event in the same cycle as clr_status keeps the flag set.
  assign overrun_d = (overrun_q & ~clr_status) | drop;
  assign ack_err_d = (ack_err_q & ~clr_status) | err_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
      ack_err_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
      ack_err_q <= ack_err_d;
    end
  end

  nexi_sync_fifo #(
    .DATA_W (UART_DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (capture),
    .wdata_i (rx_data),
    .pop_i   (pop),
    .rdata_o (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign out_valid = ~fifo_empty;
  assign overrun   = overrun_q;
  assign ack_err   = ack_err_q;
  assign irq       = (fifo_level >= IRQ_LVL) | overrun_q | ack_err_q;

`ifdef NEXI_UART_RX_CTRL_STATS_EN
  logic [15:0] rx_cnt_q, drop_cnt_q;

  function automatic logic [15:0] stat_next(input logic [15:0] cur, input logic clr,
                                            input logic inc);
    logic [15:0] base;
    base = clr ? 16'd0 : cur;
    return (inc && (base != 16'hFFFF)) ? base + 16'd1 : base;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      rx_cnt_q   <= stat_next(rx_cnt_q, clr_status, capture & ~drop);
      drop_cnt_q <= stat_next(drop_cnt_q, clr_status, drop);
    end
  end

  assign stat_rx_cnt   = rx_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule
